// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch (IF) and
// data-memory (DM) pipeline stages. A granted request holds the port for LAT
// cycles. The last busy cycle carries a one-cycle acknowledge and the read data.
//
// Handshake: a requester raises x_req_i and holds it, together with its
// address, write enable and write data, until it sees x_ack_o high. x_ack_o is
// high for exactly one cycle, and rdata_o is valid in that same cycle. After an
// ack, a still-high x_req_i counts as a new request only from the next cycle.
// A request dropped before its ack does not abort the transaction. The
// transaction runs to completion and the ack still pulses.
//
// LAT must lie in 1..15 so that LAT-1 fits in the 4-bit down-counter.
module mem_port_arbiter #(
    parameter int size = 32,
    parameter int LAT  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [size-1:0] if_addr_i,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [size-1:0] dm_addr_i,
    input  logic [size-1:0] dm_wdata_i,
    input  logic [size-1:0] mem_rdata_i,
    output logic            mem_sel_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [size-1:0] mem_addr_o,
    output logic [size-1:0] mem_wdata_o,
    output logic [size-1:0] rdata_o,
    output logic            if_ack_o,
    output logic            dm_ack_o,
    output logic            if_stall_o,
    output logic            dm_stall_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    // The counter is loaded with LAT-1, so it reaches zero in the last busy cycle.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;   // 0 = IF, 1 = DM
    logic            sel_q, sel_d;
    logic            we_q, we_d;
    logic [size-1:0] addr_q, addr_d;
    logic [size-1:0] wdata_q, wdata_d;

    logic            busy;
    logic            done;       // last busy cycle: ack cycle and re-arbitration edge
    logic            if_cand;    // IF may compete at the coming edge
    logic            dm_cand;    // DM may compete at the coming edge
    logic            grant_if;
    logic            grant_dm;

    assign busy = (state_q != IDLE);
    assign done = busy && (cnt_q == 4'd0);

    // A requester that is acknowledged this cycle may not be re-granted at the
    // same edge. It has to come back after its ack.
    assign if_cand = if_req_i && (state_q != BUSY_IF);
    assign dm_cand = dm_req_i && (state_q != BUSY_DM);

    assign dbg_state_o = state_q;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next state: round-robin arbitration in IDLE and at completion, else count down
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_if     = 1'b0;
        grant_dm     = 1'b0;

        if (!busy || done) begin
            // On a tie, the requester that was not granted last wins.
            if (if_cand && (!dm_cand || last_grant_q)) begin
                grant_if = 1'b1;
            end else if (dm_cand) begin
                grant_dm = 1'b1;
            end
        end

        if (grant_if) begin
            state_d      = BUSY_IF;
            cnt_d        = LAT_M1;
            last_grant_d = 1'b0;
            sel_d        = 1'b0;
            we_d         = 1'b0;
            addr_d       = if_addr_i;
        end else if (grant_dm) begin
            state_d      = BUSY_DM;
            cnt_d        = LAT_M1;
            last_grant_d = 1'b1;
            sel_d        = 1'b1;
            we_d         = dm_we_i;
            addr_d       = dm_addr_i;
            wdata_d      = dm_wdata_i;
        end else if (done) begin
            state_d = IDLE;
        end else if (busy) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Outputs: port control from the latches, acks and read data in the last busy cycle
    always_comb begin
        mem_sel_o   = sel_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_en_o    = busy;
        mem_we_o    = (state_q == BUSY_DM) && we_q;
        if_ack_o    = done && (state_q == BUSY_IF);
        dm_ack_o    = done && (state_q == BUSY_DM);
        rdata_o     = done ? mem_rdata_i : '0;
        if_stall_o  = if_req_i && !(done && (state_q == BUSY_IF));
        dm_stall_o  = dm_req_i && !(done && (state_q == BUSY_DM));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The main instance uses LAT=2 and a second
// instance uses LAT=1. Inputs change 1 ns after a rising edge, and outputs are
// checked in that same window, so each step() advances exactly one cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // main instance (LAT = 2)
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        mem_sel, mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [1:0]  state;

    // second instance (LAT = 1)
    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic        b_mem_sel, b_mem_en, b_mem_we, b_if_ack, b_dm_ack, b_if_stall, b_dm_stall;
    logic [31:0] b_mem_addr, b_mem_wdata, b_rdata;
    logic [1:0]  b_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.size(32), .LAT(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_sel_o(mem_sel), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .rdata_o(rdata),
        .if_ack_o(if_ack), .dm_ack_o(dm_ack),
        .if_stall_o(if_stall), .dm_stall_o(dm_stall),
        .dbg_state_o(state)
    );

    mem_port_arbiter #(.size(32), .LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr),
        .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
        .mem_rdata_i(b_mem_rdata),
        .mem_sel_o(b_mem_sel), .mem_en_o(b_mem_en), .mem_we_o(b_mem_we),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .rdata_o(b_rdata),
        .if_ack_o(b_if_ack), .dm_ack_o(b_dm_ack),
        .if_stall_o(b_if_stall), .dm_stall_o(b_dm_stall),
        .dbg_state_o(b_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 32'h1111_2222;
        b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
        b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 32'h5555_6666;
        step();
        step();

        // reset values
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_sel", 32'(mem_sel), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);

        // IF read at 0x40 with LAT=2
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk("if_stall_c0", 32'(if_stall), 32'd1);
        chk("if_en_c0", 32'(mem_en), 32'd0);
        step();
        chk("if_en_c1", 32'(mem_en), 32'd1);
        chk("if_sel_c1", 32'(mem_sel), 32'd0);
        chk("if_ack_c1", 32'(if_ack), 32'd0);
        chk("if_stall_c1", 32'(if_stall), 32'd1);
        chk("if_addr_c1", mem_addr, 32'h40);
        chk("if_rdata_c1", rdata, 32'd0);
        chk("if_state_c1", 32'(state), 32'd1);
        step();
        chk("if_en_c2", 32'(mem_en), 32'd1);
        chk("if_ack_c2", 32'(if_ack), 32'd1);
        chk("if_rdata_c2", rdata, 32'h1111_2222);
        chk("if_stall_c2", 32'(if_stall), 32'd0);
        chk("if_we_c2", 32'(mem_we), 32'd0);
        if_req = 1'b0;
        step();
        chk("if_en_c3", 32'(mem_en), 32'd0);
        chk("if_ack_c3", 32'(if_ack), 32'd0);
        chk("if_addr_hold", mem_addr, 32'h40);
        chk("if_state_c3", 32'(state), 32'd0);

        // DM write of 0xDEADBEEF to 0x100
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("dmw_en_c1", 32'(mem_en), 32'd1);
        chk("dmw_sel_c1", 32'(mem_sel), 32'd1);
        chk("dmw_we_c1", 32'(mem_we), 32'd1);
        chk("dmw_addr_c1", mem_addr, 32'h100);
        chk("dmw_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
        chk("dmw_ack_c1", 32'(dm_ack), 32'd0);
        chk("dmw_stall_c1", 32'(dm_stall), 32'd1);
        step();
        chk("dmw_we_c2", 32'(mem_we), 32'd1);
        chk("dmw_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
        chk("dmw_ack_c2", 32'(dm_ack), 32'd1);
        chk("dmw_stall_c2", 32'(dm_stall), 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("dmw_we_c3", 32'(mem_we), 32'd0);
        chk("dmw_en_c3", 32'(mem_en), 32'd0);
        chk("dmw_ack_c3", 32'(dm_ack), 32'd0);
        chk("dmw_sel_hold", 32'(mem_sel), 32'd1);
        chk("dmw_wdata_hold", mem_wdata, 32'hDEAD_BEEF);

        // both requesters held: DM was granted last, so IF wins the tie and grants alternate
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            step();
            mem_rdata = 32'h3000_0000 | 32'(i);
            #1;
            chk("rr_en", 32'(mem_en), 32'd1);
            chk("rr_sel", 32'(mem_sel), 32'((i >> 1) & 1));
            chk("rr_addr", mem_addr, ((i >> 1) & 1) != 0 ? 32'h200 : 32'h80);
            chk("rr_if_ack", 32'(if_ack), 32'((i % 4) == 1));
            chk("rr_dm_ack", 32'(dm_ack), 32'((i % 4) == 3));
            chk("rr_rdata", rdata, ((i % 2) == 1) ? (32'h3000_0000 | 32'(i)) : 32'd0);
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();
        chk("rr_end_en", 32'(mem_en), 32'd0);
        chk("rr_end_sel", 32'(mem_sel), 32'd1);

        // only IF, request held: one idle cycle between transactions
        if_req = 1'b1; if_addr = 32'h44;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("rep_en", 32'(mem_en), 32'((i % 3) != 0));
            chk("rep_ack", 32'(if_ack), 32'((i % 3) == 2));
            chk("rep_dm_ack", 32'(dm_ack), 32'd0);
        end
        if_req = 1'b0;
        step();
        chk("rep_end_en", 32'(mem_en), 32'd0);

        // reset in the first busy cycle of a DM write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_0001;
        step();
        chk("rstb_en", 32'(mem_en), 32'd1);
        chk("rstb_we", 32'(mem_we), 32'd1);
        chk("rstb_state", 32'(state), 32'd2);
        rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("rstb_state_after", 32'(state), 32'd0);
        chk("rstb_en_after", 32'(mem_en), 32'd0);
        chk("rstb_we_after", 32'(mem_we), 32'd0);
        chk("rstb_ack_after", 32'(dm_ack), 32'd0);
        chk("rstb_sel_after", 32'(mem_sel), 32'd0);
        chk("rstb_addr_after", mem_addr, 32'd0);
        chk("rstb_wdata_after", mem_wdata, 32'd0);
        chk("rstb_rdata_after", rdata, 32'd0);
        step();
        chk("rstb_ack_later", 32'(dm_ack), 32'd0);

        // LAT=1 instance: tie right after reset, so IF goes first
        rst = 1'b0;
        b_if_req = 1'b1; b_if_addr = 32'h10;
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h20;
        step();
        chk("l1_if_ack_c1", 32'(b_if_ack), 32'd1);
        chk("l1_dm_ack_c1", 32'(b_dm_ack), 32'd0);
        chk("l1_sel_c1", 32'(b_mem_sel), 32'd0);
        chk("l1_en_c1", 32'(b_mem_en), 32'd1);
        chk("l1_addr_c1", b_mem_addr, 32'h10);
        chk("l1_rdata_c1", b_rdata, 32'h5555_6666);
        b_if_req = 1'b0;
        step();
        chk("l1_dm_ack_c2", 32'(b_dm_ack), 32'd1);
        chk("l1_if_ack_c2", 32'(b_if_ack), 32'd0);
        chk("l1_sel_c2", 32'(b_mem_sel), 32'd1);
        chk("l1_addr_c2", b_mem_addr, 32'h20);
        b_dm_req = 1'b0;
        step();
        chk("l1_en_c3", 32'(b_mem_en), 32'd0);
        chk("l1_acks_c3", {30'd0, b_if_ack, b_dm_ack}, 32'd0);

        // IF request dropped mid-transaction: the ack still pulses and the port frees up
        if_req = 1'b1; if_addr = 32'h50; mem_rdata = 32'h7777_8888;
        step();
        chk("drop_en_c1", 32'(mem_en), 32'd1);
        if_req = 1'b0;
        #1;
        chk("drop_stall", 32'(if_stall), 32'd0);
        step();
        chk("drop_ack_c2", 32'(if_ack), 32'd1);
        chk("drop_rdata_c2", rdata, 32'h7777_8888);
        step();
        chk("drop_en_c3", 32'(mem_en), 32'd0);
        chk("drop_state_c3", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported memory between the instruction-fetch (IF) and data-memory (DM) stages of the pipelined CPU. It latches a request, holds the memory port for a fixed access latency, and returns a one-cycle acknowledge with read data. It also drives the select line of the 2-to-1 address/data multiplexer in front of the memory, and drives per-stage stall signals to the hazard logic.

## Interface
- size, 32, width of address and data buses
- LAT, 2, memory access latency in cycles (legal range 1..15)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- if_req_i  input  1  IF read request; held until if_ack_o
- if_addr_i  input  size  IF read address
- dm_req_i  input  1  DM request; held until dm_ack_o
- dm_we_i  input  1  DM write enable (1 = write, 0 = read)
- dm_addr_i  input  size  DM address
- dm_wdata_i  input  size  DM write data
- mem_rdata_i  input  size  memory read data, valid in the last busy cycle
- mem_sel_o  output  1  port-mux select: 0 = IF, 1 = DM
- mem_en_o  output  1  memory enable, high in every busy cycle
- mem_we_o  output  1  memory write enable (DM writes only)
- mem_addr_o  output  size  latched address of the granted request
- mem_wdata_o  output  size  latched DM write data
- rdata_o  output  size  equals mem_rdata_i during an ack cycle, otherwise 0
- if_ack_o  output  1  one-cycle completion pulse for IF
- dm_ack_o  output  1  one-cycle completion pulse for DM
- if_stall_o  output  1  if_req_i & ~if_ack_o
- dm_stall_o  output  1  dm_req_i & ~dm_ack_o

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- Registers:
  - 4-bit down-counter cnt.
  - last_grant (0 = IF, 1 = DM).
  - Latched addr, we, and wdata.
- Arbitration in IDLE at each rising edge:
  - Only IF requesting: go to BUSY_IF.
  - Only DM requesting: go to BUSY_DM.
  - Both requesting: grant the requester that is not last_grant (round-robin).
  - On every grant: latch that requester's addr (plus we and wdata for DM); load cnt = LAT-1; set last_grant.
- BUSY_x:
  - mem_en_o = 1, mem_sel_o = x, and mem_addr_o, mem_we_o and mem_wdata_o come from the latches.
  - cnt decrements each cycle.
  - When cnt == 0: assert x_ack_o and drive rdata_o = mem_rdata_i (for writes rdata_o is don't-care).
- Completion edge (cnt == 0):
  - Re-arbitrate immediately using the IDLE rules, but exclude the requester being acknowledged in that cycle.
  - If the other requester is pending, enter its BUSY state directly with no bubble; otherwise go to IDLE.
- A requester must present a new request after its ack. A held req is treated as a new request only from the cycle after the ack.
- IF never writes: mem_we_o = 0 in BUSY_IF. mem_we_o = latched we in BUSY_DM.
- In IDLE, mem_sel_o holds its last value; mem_en_o, mem_we_o, acks and rdata_o are 0; mem_addr_o and mem_wdata_o hold.
- Req dropped before ack is a protocol violation. The transaction still completes and the ack still pulses; the arbiter must not hang.

## Timing
- Reset values:
  - State IDLE, cnt 0, last_grant 1, so IF wins the first tie and DM the next.
  - mem_sel_o 0, mem_en_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, rdata_o 0, both acks 0.
- Latency: req first sampled high at edge E. The port is busy in cycles E+1 .. E+LAT, and the ack is high in cycle E+LAT.
- Back-to-back from different requesters: the second transaction's first busy cycle is the cycle after the first ack.
- Same requester repeating: one idle cycle between ack and the next busy cycle.
- Stall outputs are combinational from req and ack, with no added latency.
- Reset during BUSY: state becomes IDLE at that edge and no ack is issued for the dropped transaction. mem_en_o and mem_we_o are 0 in the following cycle.
- LAT = 1: every busy cycle is also the ack cycle.

## Test plan
- Reset, then if_req_i=1 with addr 0x40 at edge 0, LAT=2 -> mem_en_o=1 and mem_sel_o=0 in cycles 1–2; if_ack_o=1 in cycle 2 with rdata_o = mem_rdata_i; if_stall_o=1 in cycles 0–1.
- DM write: dm_we_i=1, addr 0x100, wdata 0xDEADBEEF -> mem_we_o=1, mem_sel_o=1 and mem_wdata_o=0xDEADBEEF for 2 cycles; dm_ack_o pulses once; mem_we_o=0 afterwards.
- Both requests held continuously from reset -> grants alternate IF, DM, IF, DM with no bubbles; every ack is exactly 1 cycle; mem_sel_o toggles every LAT cycles.
- Only IF requesting, req held high -> acks in cycles 2, 5, 8 (one idle cycle between transactions).
- Assert rst_i in cycle 1 of BUSY_DM with a write -> no dm_ack_o; mem_we_o=0 and state IDLE in the next cycle; all outputs equal their reset values.
- LAT=1 with DM and IF both requesting -> IF ack in cycle 1, DM ack in cycle 2.
